// File: rtl/fp_widen_pipe.sv
// Three-stage valid/ready pipeline widening {sign, exp, man} floating point to a wider format.
// Denormals are normalised; zero, inf and NaN (payload unchanged) are preserved.
module fp_widen_pipe #(
    parameter int WI   = 40,
    parameter int EI   = 10,
    parameter int WO   = 80,
    parameter int EO   = 15,
    parameter int TAGW = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [WI-1:0]   a_i,
    input  logic [TAGW-1:0] tag_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [WO-1:0]   o_o,
    output logic [TAGW-1:0] tag_o,
    output logic            denorm_o,
    output logic            snan_o
);

    localparam int MI  = WI - 1 - EI;
    localparam int MO  = WO - 1 - EO;
    localparam int LZW = (MI > 1) ? $clog2(MI) : 1;
    localparam int BI  = (1 << (EI - 1)) - 1;
    localparam int BO  = (1 << (EO - 1)) - 1;
    localparam logic [EO-1:0] DX = EO'(BO - BI);

    function automatic logic [LZW-1:0] lzc(input logic [MI-1:0] m);
        lzc = '0;
        // Scanning upward lets the highest set bit win.
        for (int unsigned i = 0; i < MI; i++) begin
            if (m[i]) lzc = LZW'(unsigned'(MI) - 1 - i);
        end
    endfunction

    logic v1, v2, v3;
    logic en1, en2, en3;

    assign en3     = ~v3 | ready_i;
    assign en2     = ~v2 | en3;
    assign en1     = ~v1 | en2;
    assign ready_o = en1;
    assign valid_o = v3;

    // Stage 1: decompose and classify
    logic            s1_sign, s1_vz, s1_xz, s1_xinf;
    logic [EI-1:0]   s1_exp;
    logic [MI-1:0]   s1_man;
    logic [TAGW-1:0] s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_vz   <= 1'b0;
            s1_xz   <= 1'b0;
            s1_xinf <= 1'b0;
            s1_exp  <= '0;
            s1_man  <= '0;
            s1_tag  <= '0;
        end else begin
            if (flush_i)  v1 <= 1'b0;
            else if (en1) v1 <= valid_i;
            if (en1 && valid_i && !flush_i) begin
                s1_sign <= a_i[WI-1];
                s1_exp  <= a_i[WI-2 -: EI];
                s1_man  <= a_i[MI-1:0];
                s1_xz   <= (a_i[WI-2 -: EI] == '0);
                s1_vz   <= (a_i[WI-2 -: EI] == '0) && (a_i[MI-1:0] == '0);
                s1_xinf <= (a_i[WI-2 -: EI] == '1);
                s1_tag  <= tag_i;
            end
        end
    end

    // Stage 2: leading-zero count
    logic            s2_sign, s2_vz, s2_xz, s2_xinf;
    logic [EI-1:0]   s2_exp;
    logic [MI-1:0]   s2_man;
    logic [LZW-1:0]  s2_lz;
    logic [TAGW-1:0] s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2      <= 1'b0;
            s2_sign <= 1'b0;
            s2_vz   <= 1'b0;
            s2_xz   <= 1'b0;
            s2_xinf <= 1'b0;
            s2_exp  <= '0;
            s2_man  <= '0;
            s2_lz   <= '0;
            s2_tag  <= '0;
        end else begin
            if (flush_i)  v2 <= 1'b0;
            else if (en2) v2 <= v1;
            if (en2 && v1) begin
                s2_sign <= s1_sign;
                s2_vz   <= s1_vz;
                s2_xz   <= s1_xz;
                s2_xinf <= s1_xinf;
                s2_exp  <= s1_exp;
                s2_man  <= s1_man;
                s2_lz   <= lzc(s1_man);
                s2_tag  <= s1_tag;
            end
        end
    end

    // Stage 3: pack into the wide format
    logic [EO-1:0] pk_exp;
    logic [MO-1:0] pk_man;
    logic [MI-1:0] nm;
    logic          pk_den, pk_snan;

    always_comb begin
        pk_exp  = '0;
        pk_man  = '0;
        nm      = '0;
        pk_den  = s2_xz & ~s2_vz;
        pk_snan = s2_xinf & (|s2_man) & ~s2_man[MI-1];
        if (s2_vz) begin
            pk_exp = '0;
        end else if (s2_xinf) begin
            pk_exp            = '1;
            pk_man[MO-1 -: MI] = s2_man;
        end else if (s2_xz) begin
            // Shift one past the leading one so the implicit bit drops off the top.
            nm                 = (s2_man << s2_lz) << 1;
            pk_exp             = DX - EO'(s2_lz);
            pk_man[MO-1 -: MI] = nm;
        end else begin
            pk_exp             = EO'(s2_exp) + DX;
            pk_man[MO-1 -: MI] = s2_man;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3       <= 1'b0;
            o_o      <= '0;
            tag_o    <= '0;
            denorm_o <= 1'b0;
            snan_o   <= 1'b0;
        end else begin
            if (flush_i)  v3 <= 1'b0;
            else if (en3) v3 <= v2;
            if (en3 && v2) begin
                o_o      <= {s2_sign, pk_exp, pk_man};
                tag_o    <= s2_tag;
                denorm_o <= pk_den;
                snan_o   <= pk_snan;
            end
        end
    end

endmodule
